// File: rtl/ascon_block_packer.sv
// Byte-stream to rate-block packer for the ASCON core: packs 8/16-byte blocks
// MSB-first, applies 10* padding and flags the final and pad-only blocks.
module ascon_block_packer (
  input  logic         clk,
  input  logic         rstn,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [127:0] blk_data,
  output logic [4:0]   blk_nbytes,
  output logic         blk_last,
  output logic         blk_pad_only
);

  typedef enum logic [0:0] {StFill, StOut} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic [127:0]   buf_q, buf_d;
  logic [4:0]     nbytes_q, nbytes_d;
  logic           last_q, last_d;
  logic           pad_only_q, pad_only_d;
  logic           pend_pad_q, pend_pad_d;

  logic           cur_mode;
  logic [3:0]     pos, pos_nxt;
  logic           blk_full;

  function automatic logic [127:0] pad_block(input logic m);
    return m ? {8'h80, 120'h0} : {64'h0, 8'h80, 56'h0};
  endfunction

  // Mode is only sampled on the first byte of a block; afterwards the latched copy rules.
  assign cur_mode = (cnt_q == 4'd0) ? mode : mode_q;
  // Byte position counted from the MSB of the 128-bit field; mode 0 uses the low half.
  assign pos      = cur_mode ? cnt_q : cnt_q + 4'd8;
  assign pos_nxt  = pos + 4'd1;
  assign blk_full = (cnt_q == (cur_mode ? 4'd15 : 4'd7));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StFill;
      cnt_q      <= 4'd0;
      mode_q     <= 1'b0;
      buf_q      <= '0;
      nbytes_q   <= 5'd0;
      last_q     <= 1'b0;
      pad_only_q <= 1'b0;
      pend_pad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      buf_q      <= buf_d;
      nbytes_q   <= nbytes_d;
      last_q     <= last_d;
      pad_only_q <= pad_only_d;
      pend_pad_q <= pend_pad_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    buf_d      = buf_q;
    nbytes_d   = nbytes_q;
    last_d     = last_q;
    pad_only_d = pad_only_q;
    pend_pad_d = pend_pad_q;
    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          mode_d = cur_mode;
          if (in_empty) begin
            buf_d      = pad_block(cur_mode);
            nbytes_d   = 5'd0;
            last_d     = 1'b1;
            pad_only_d = 1'b1;
            state_d    = StOut;
          end else begin
            buf_d[{~pos, 3'b000} +: 8] = in_byte;
            if (blk_full) begin
              nbytes_d   = cur_mode ? 5'd16 : 5'd8;
              last_d     = 1'b0;
              pend_pad_d = in_last;
              state_d    = StOut;
            end else if (in_last) begin
              buf_d[{~pos_nxt, 3'b000} +: 8] = 8'h80;
              nbytes_d = {1'b0, cnt_q} + 5'd1;
              last_d   = 1'b1;
              state_d  = StOut;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
      end
      StOut: begin
        if (blk_ready) begin
          if (pend_pad_q) begin
            buf_d      = pad_block(mode_q);
            nbytes_d   = 5'd0;
            last_d     = 1'b1;
            pad_only_d = 1'b1;
            pend_pad_d = 1'b0;
          end else begin
            buf_d      = '0;
            cnt_d      = 4'd0;
            nbytes_d   = 5'd0;
            last_d     = 1'b0;
            pad_only_d = 1'b0;
            state_d    = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == StFill);
    blk_valid    = (state_q == StOut);
    blk_data     = buf_q;
    blk_nbytes   = nbytes_q;
    blk_last     = last_q;
    blk_pad_only = pad_only_q;
  end

endmodule

// File: tb/tb_ascon_block_packer.sv
// Scoreboard bench for ascon_block_packer: directed messages push expected
// blocks; a monitor pops and compares on every block transfer.
module tb_ascon_block_packer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_byte = 8'h00;
  logic         in_last = 1'b0;
  logic         in_empty = 1'b0;
  logic         blk_valid;
  logic         blk_ready = 1'b1;
  logic [127:0] blk_data;
  logic [4:0]   blk_nbytes;
  logic         blk_last;
  logic         blk_pad_only;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   nbytes;
    logic         last;
    logic         pad_only;
  } blk_t;

  blk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ascon_block_packer dut (
    .clk          (clk),
    .rstn         (rstn),
    .mode         (mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .in_last      (in_last),
    .in_empty     (in_empty),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_nbytes   (blk_nbytes),
    .blk_last     (blk_last),
    .blk_pad_only (blk_pad_only)
  );

  // Monitor: every transferred block must match the head of the scoreboard.
  initial begin
    blk_t e;
    forever begin
      @(negedge clk);
      if (rstn && blk_valid && blk_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_block: got data=%h nbytes=%0d last=%b pad=%b, required none",
                   blk_data, blk_nbytes, blk_last, blk_pad_only);
        end else begin
          e = exp_q.pop_front();
          if (blk_data !== e.data || blk_nbytes !== e.nbytes || blk_last !== e.last ||
              blk_pad_only !== e.pad_only) begin
            errors++;
            $display("FAIL block: got data=%h nbytes=%0d last=%b pad=%b, required data=%h nbytes=%0d last=%b pad=%b",
                     blk_data, blk_nbytes, blk_last, blk_pad_only,
                     e.data, e.nbytes, e.last, e.pad_only);
          end
        end
      end
    end
  end

  task automatic push(input logic [127:0] d, input logic [4:0] n, input logic l, input logic p);
    blk_t e;
    e.data = d; e.nbytes = n; e.last = l; e.pad_only = p;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic l, input logic e);
    int t = 0;
    in_valid = 1'b1; in_byte = b; in_last = l; in_empty = e;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic wait_blk_valid();
    int t = 0;
    while (!blk_valid && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!blk_valid) begin
      checks++; errors++;
      $display("FAIL blk_valid_timeout: blk_valid=%b, required 1", blk_valid);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 200) begin
      @(posedge clk); #1; t++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (blk_valid !== 1'b0 || blk_data !== 128'h0 || blk_nbytes !== 5'd0 ||
        blk_last !== 1'b0 || blk_pad_only !== 1'b0) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h nbytes=%0d last=%b pad=%b, required all 0",
               name, blk_valid, blk_data, blk_nbytes, blk_last, blk_pad_only);
    end
  endtask

  task automatic pulse_reset(input string name);
    rstn = 1'b0;
    #1;
    check_reset_outputs(name);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b, required 1", name, in_ready);
    end
  endtask

  initial begin
    logic [7:0] b;
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Mode 0 short message; mode flips after byte 0 and must be ignored.
    mode = 1'b0;
    push({64'h0, 64'h0102030405800000}, 5'd5, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    mode = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      b = 8'(i);
      send(b, i == 5, 1'b0);
    end
    drain();

    // Mode 0, exact rate multiple: data block then pad-only block.
    mode = 1'b0;
    push({64'h0, 64'h1112131415161718}, 5'd8, 1'b0, 1'b0);
    push({64'h0, 64'h8000000000000000}, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      b = 8'h11 + 8'(i);
      send(b, i == 7, 1'b0);
    end
    drain();

    // Mode 1, empty message.
    mode = 1'b1;
    push({8'h80, 120'h0}, 5'd0, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    drain();

    // Mode 1, 17 bytes 00..10.
    push(128'h000102030405060708090A0B0C0D0E0F, 5'd16, 1'b0, 1'b0);
    push(128'h10800000000000000000000000000000, 5'd1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      b = 8'(i);
      send(b, i == 16, 1'b0);
    end
    drain();

    // Backpressure: block held for 3 cycles while a byte is offered.
    mode = 1'b0;
    blk_ready = 1'b0;
    push({64'h0, 64'hA1A2A38000000000}, 5'd3, 1'b1, 1'b0);
    push({64'h0, 64'h5580000000000000}, 5'd1, 1'b1, 1'b0);
    send(8'hA1, 1'b0, 1'b0);
    send(8'hA2, 1'b0, 1'b0);
    send(8'hA3, 1'b1, 1'b0);
    wait_blk_valid();
    in_valid = 1'b1; in_byte = 8'h55; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (blk_valid !== 1'b1 || blk_data !== {64'h0, 64'hA1A2A38000000000} ||
          blk_nbytes !== 5'd3 || blk_last !== 1'b1 || blk_pad_only !== 1'b0 ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got valid=%b data=%h nbytes=%0d last=%b pad=%b in_ready=%b, required 1 a1a2a38000000000 3 1 0 0",
                 i, blk_valid, blk_data, blk_nbytes, blk_last, blk_pad_only, in_ready);
      end
    end
    @(posedge clk); #1;
    blk_ready = 1'b1;
    send(8'h55, 1'b1, 1'b0);
    drain();

    // Reset after 3 bytes in mode 1: the partial block is discarded.
    mode = 1'b1;
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    pulse_reset("reset_mid_block");

    // Reset while the appended pad block is presented.
    mode = 1'b0;
    blk_ready = 1'b0;
    push({64'h0, 64'h2122232425262728}, 5'd8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      b = 8'h21 + 8'(i);
      send(b, i == 7, 1'b0);
    end
    wait_blk_valid();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
    checks++;
    if (blk_valid !== 1'b1 || blk_pad_only !== 1'b1) begin
      errors++;
      $display("FAIL pend_pad_present: got valid=%b pad=%b, required 1 1", blk_valid, blk_pad_only);
    end
    pulse_reset("reset_pend_pad");
    blk_ready = 1'b1;

    // New message after reset.
    mode = 1'b1;
    push({8'hAA, 8'hBB, 8'h80, 104'h0}, 5'd2, 1'b1, 1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b1, 1'b0);
    drain();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending blocks, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
